// File: rtl/control_unit_if.sv
// Instruction-field / control-word bundle between the fetch stage and the
// main decoder of a single-issue RV32I core.
//
// Transfer rule: there is no valid/ready pair on this bundle. The decoder
// accepts a new {opcode, funct3, funct7} on every cycle and always presents
// a control word for it. With registered outputs, that control word appears
// one rising clk edge later. With combinational outputs, it appears in the
// same cycle.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       reg_write;
  logic       mem_write;
  logic       alu_src;
  logic [1:0] alu_src_a;
  logic [1:0] result_src;
  logic       branch;
  logic       jump;
  logic       jalr;
  logic [3:0] alu_ctrl;
  logic       illegal;

  // Instruction source side (fetch stage or testbench).
  modport master (
    output opcode, funct3, funct7,
    input  reg_write, mem_write, alu_src, alu_src_a, result_src,
           branch, jump, jalr, alu_ctrl, illegal
  );

  // Decoder side.
  modport slave (
    input  opcode, funct3, funct7,
    output reg_write, mem_write, alu_src, alu_src_a, result_src,
           branch, jump, jalr, alu_ctrl, illegal
  );
endinterface

// File: rtl/control_unit.sv
// RV32I main decoder. It maps {opcode, funct3, funct7} to the datapath
// control word. Unsupported encodings raise illegal and decode as a NOP.
// With REG_OUT=1 the control word is registered, giving one cycle of
// latency, and reset clears it asynchronously.
module control_unit #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_src_a;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_ctrl;
    logic       illegal;
  } ctrl_t;

  // An all-zero word is a NOP: no writes, no control flow, and ALU = ADD.
  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // Shared funct3 ALU map for R-type and I-ALU. alt selects SUB/SRA.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // R-type accepts funct7=0 on every funct3.
  // It accepts funct7=0100000 only on funct3 000 (SUB) and 101 (SRA).
  logic r_funct_ok;
  assign r_funct_ok = (bus.funct7 == 7'b0000000) ||
                      ((bus.funct7 == 7'b0100000) &&
                       ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));

  // Combinational decode of the current instruction fields.
  always_comb begin
    dec = CTRL_NOP;
    case (bus.opcode)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRC_A_RS1;
        dec.result_src = RES_MEM;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = SRC_A_RS1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_R: begin
        if (r_funct_ok) begin
          dec.reg_write  = 1'b1;
          dec.alu_src    = 1'b0;
          dec.result_src = RES_ALU;
          dec.alu_ctrl   = alu_fn(bus.funct3, bus.funct7[5]);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        // Immediates have no SUB. funct7[5] matters only for shift-right.
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_ALU;
        dec.alu_ctrl   = alu_fn(bus.funct3,
                                (bus.funct3 == 3'b101) && bus.funct7[5]);
      end
      OP_BRANCH: begin
        case (bus.funct3)
          3'b000, 3'b001: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
          end
          3'b100, 3'b101: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SLT;
          end
          3'b110, 3'b111: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SLTU;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRC_A_PC;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_JALR: begin
        if (bus.funct3 == 3'b000) begin
          dec.reg_write  = 1'b1;
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.result_src = RES_PC4;
          dec.alu_src    = 1'b1;
          dec.alu_src_a  = SRC_A_RS1;
          dec.alu_ctrl   = ALU_ADD;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRC_A_ZERO;
        dec.result_src = RES_ALU;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRC_A_PC;
        dec.result_src = RES_ALU;
        dec.alu_ctrl   = ALU_ADD;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      // Register the control word. Reset forces a NOP immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_q <= CTRL_NOP;
        end else begin
          ctrl_q <= dec;
        end
      end
    end else begin : g_comb
      assign ctrl_q = dec;
    end
  endgenerate

  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.branch     = ctrl_q.branch;
  assign bus.jump       = ctrl_q.jump;
  assign bus.jalr       = ctrl_q.jalr;
  assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
  assign bus.illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with registered outputs.
// The driver pushes hand-computed control words into a scoreboard queue.
// A monitor pops one entry one cycle later and compares it with the outputs.
module tb_control_unit;

  // Packed order: {reg_write, mem_write, alu_src, alu_src_a, result_src,
  //                branch, jump, jalr, alu_ctrl, illegal}
  localparam int W = 15;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  control_unit_if bus ();

  control_unit #(.REG_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a control word from individual fields.
  function automatic logic [W-1:0] mk(input logic rw, input logic mw,
                                      input logic as, input logic [1:0] sa,
                                      input logic [1:0] rs, input logic br,
                                      input logic j, input logic jr,
                                      input logic [3:0] alu, input logic ill);
    return {rw, mw, as, sa, rs, br, j, jr, alu, ill};
  endfunction

  function automatic logic [W-1:0] actual();
    return {bus.reg_write, bus.mem_write, bus.alu_src, bus.alu_src_a,
            bus.result_src, bus.branch, bus.jump, bus.jalr, bus.alu_ctrl,
            bus.illegal};
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = actual();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [W-1:0] exp,
                       input string name);
    @(negedge clk);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_A = 7'b0100000;
  localparam logic [W-1:0] NOP = '0;
  localparam logic [W-1:0] ILL = 15'b000_00_00_000_0000_1;
  localparam logic [W-1:0] R_ADD = 15'b100_00_00_000_0000_0;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.opcode = 7'b0000011;
    bus.funct3 = 3'b010;
    bus.funct7 = F7_0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", NOP);
    @(negedge clk);
    rst_n = 1'b1;

    //                                  rw mw as sa     rs     br j  jr alu      ill
    apply(7'b0000011, 3'b010, F7_0, mk(1, 0, 1, 2'b00, 2'b01, 0, 0, 0, 4'b0000, 0), "load");
    apply(7'b0100011, 3'b010, F7_0, mk(0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0000, 0), "store");
    apply(7'b0110011, 3'b000, F7_0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0000, 0), "r_add");
    apply(7'b0110011, 3'b000, F7_A, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0001, 0), "r_sub");
    apply(7'b0110011, 3'b101, F7_A, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0111, 0), "r_sra");
    apply(7'b0110011, 3'b101, F7_0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0110, 0), "r_srl");
    apply(7'b0110011, 3'b011, F7_0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b1001, 0), "r_sltu");
    apply(7'b0110011, 3'b111, F7_0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0010, 0), "r_and");
    apply(7'b0110011, 3'b110, F7_0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4'b0011, 0), "r_or");
    apply(7'b0110011, 3'b001, F7_A, ILL, "r_ill_sll_alt");
    apply(7'b0110011, 3'b000, 7'b0000001, ILL, "r_ill_f7");
    apply(7'b0010011, 3'b000, F7_A, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0000, 0), "i_addi_nosub");
    apply(7'b0010011, 3'b101, F7_A, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0111, 0), "i_srai");
    apply(7'b0010011, 3'b101, F7_0, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0110, 0), "i_srli");
    apply(7'b0010011, 3'b001, F7_0, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0101, 0), "i_slli");
    apply(7'b0010011, 3'b100, F7_0, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 0), "i_xori");
    apply(7'b0010011, 3'b010, 7'b1111111, mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4'b1000, 0), "i_slti");
    apply(7'b1100011, 3'b000, F7_0, mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 4'b0001, 0), "beq");
    apply(7'b1100011, 3'b100, F7_0, mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 4'b1000, 0), "blt");
    apply(7'b1100011, 3'b111, F7_0, mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 4'b1001, 0), "bgeu");
    apply(7'b1100011, 3'b010, F7_0, ILL, "branch_ill_010");
    apply(7'b1100011, 3'b011, F7_0, ILL, "branch_ill_011");
    apply(7'b1101111, 3'b000, F7_0, mk(1, 0, 1, 2'b01, 2'b10, 0, 1, 0, 4'b0000, 0), "jal");
    apply(7'b1100111, 3'b000, F7_0, mk(1, 0, 1, 2'b00, 2'b10, 0, 1, 1, 4'b0000, 0), "jalr");
    apply(7'b1100111, 3'b001, F7_0, ILL, "jalr_ill_f3");
    apply(7'b0110111, 3'b000, F7_0, mk(1, 0, 1, 2'b10, 2'b00, 0, 0, 0, 4'b0000, 0), "lui");
    apply(7'b0010111, 3'b000, F7_0, mk(1, 0, 1, 2'b01, 2'b00, 0, 0, 0, 4'b0000, 0), "auipc");
    apply(7'b0000000, 3'b000, F7_0, ILL, "op_zero");
    apply(7'b1111111, 3'b111, 7'b1111111, ILL, "op_ones");
    drain();

    // Assert reset mid-cycle while an R-type decode is held at the outputs.
    apply(7'b0110011, 3'b000, F7_0, R_ADD, "pre_reset_r_add");
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", NOP);
    @(posedge clk);
    #1;
    check("reset_hold_edge", NOP);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", NOP);
    @(posedge clk);
    #1;
    check("reset_first_edge", R_ADD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop if the stimulus never reaches its summary line.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter REG_OUT, default 1: 1 = all outputs registered (one-cycle latency); 0 = outputs purely combinational from the inputs, and clk and rst_n are unused.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  7  instruction bits [6:0].
REQ-006 funct3  in  3  instruction bits [14:12].
REQ-007 funct7  in  7  instruction bits [31:25].
REQ-008 reg_write  out  1  register-file write enable.
REQ-009 mem_write  out  1  data-memory write enable.
REQ-010 alu_src  out  1  ALU operand B select: 0 = rs2, 1 = immediate.
REQ-011 alu_src_a  out  2  ALU operand A select: 00 = rs1, 01 = PC, 10 = zero; 11 is never driven.
REQ-012 result_src  out  2  write-back select: 00 = ALU, 01 = memory, 10 = PC+4; 11 is never driven.
REQ-013 branch  out  1  conditional-branch instruction.
REQ-014 jump  out  1  JAL or JALR.
REQ-015 jalr  out  1  JALR (target = rs1 + imm).
REQ-016 alu_ctrl  out  4  ALU operation code.
REQ-017 illegal  out  1  unsupported opcode or funct combination.

Function
REQ-018 alu_ctrl encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
REQ-019 LOAD (0000011) SHALL decode as: reg_write=1, alu_src=1, alu_src_a=00, result_src=01, alu_ctrl=ADD, all other controls 0.
REQ-020 STORE (0100011) SHALL decode as: mem_write=1, alu_src=1, alu_src_a=00, alu_ctrl=ADD, reg_write=0, all other controls 0.
REQ-021 R-type (0110011) SHALL decode as: reg_write=1, alu_src=0, result_src=00.
  - alu_ctrl from funct3: 000 ADD, or SUB if funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7[5]=1; 110 OR; 111 AND.
REQ-022 I-ALU (0010011) SHALL decode as R-type except alu_src=1, with these funct rules:
  - funct3=000 is always ADD; no SUB for immediates.
  - funct3=101 uses funct7[5] to select SRA over SRL.
REQ-023 BRANCH (0110011 excluded; opcode 1100011) SHALL decode as: branch=1, alu_src=0, reg_write=0, mem_write=0.
  - alu_ctrl: funct3 000/001 SUB; 100/101 SLT; 110/111 SLTU.
REQ-024 JAL (1101111) SHALL decode as: reg_write=1, jump=1, jalr=0, result_src=10, alu_src=1, alu_src_a=01, alu_ctrl=ADD.
REQ-025 JALR (1100111) SHALL decode as: reg_write=1, jump=1, jalr=1, result_src=10, alu_src=1, alu_src_a=00, alu_ctrl=ADD.
REQ-026 LUI (0110111) SHALL decode as: reg_write=1, alu_src=1, alu_src_a=10, alu_ctrl=ADD, result_src=00.
REQ-027 AUIPC (0010111) SHALL decode as: reg_write=1, alu_src=1, alu_src_a=01, alu_ctrl=ADD, result_src=00.
REQ-028 illegal=1 SHALL be raised for any of the following, with all write and flow controls 0 (reg_write, mem_write, branch, jump, jalr) and alu_ctrl=ADD:
  - any other opcode;
  - BRANCH with funct3 010/011;
  - JALR with funct3≠000;
  - R-type with funct7 other than 0000000, or other than 0100000 on funct3 000/101.
REQ-029 Among the outputs, only alu_ctrl SHALL depend on funct7, and only through funct7[5], except for the illegal check in REQ-028.
REQ-030 With REG_OUT=1, outputs SHALL reflect the inputs sampled at the previous rising clk edge.
REQ-031 Outputs SHALL never be X when the inputs are known.
REQ-032 At most one of {mem_write, branch, jump} SHALL be 1 at any time.
REQ-033 jalr=1 SHALL imply jump=1.

Reset
REQ-034 While rst_n=0, all outputs SHALL be 0 (a NOP: no writes, no branch or jump, alu_ctrl=ADD), asynchronously and regardless of clk.
REQ-035 After rst_n deasserts, the first rising edge SHALL load the decode of the current inputs.
REQ-036 Asserting reset mid-stream SHALL clear the outputs immediately; no decode is pending afterward.

Verification
REQ-037 LOAD opcode=0000011 -> next cycle: reg_write=1, alu_src=1, result_src=01, mem_write=0, alu_ctrl=0000.
REQ-038 STORE opcode=0100011 -> mem_write=1, reg_write=0, alu_src=1, branch=0.
REQ-039 R-type opcode=0110011, funct3=000:
  - funct7=0000000 -> alu_ctrl=0000, alu_src=0, reg_write=1;
  - funct7=0100000 -> alu_ctrl=0001.
REQ-040 BRANCH opcode=1100011, funct3=000 -> branch=1, alu_ctrl=0001, reg_write=0; JAL 1101111 -> jump=1, jalr=0, result_src=10, alu_src_a=01.
REQ-041 JALR 1100111, funct3=000 -> jump=1, jalr=1, result_src=10, reg_write=1; opcode=0000000 -> illegal=1, reg_write=0.
REQ-042 rst_n=0 asserted between clock edges while decoding R-type -> all outputs 0 immediately; they stay 0 until the first rising edge after release.
